// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Qualifies the PLL lock flag and produces the core-domain reset. Lock must be
// seen continuously for LOCK_STABLE_CYCLES. After that the reset is held for a
// further RESET_HOLD_CYCLES. A loss of lock or a soft reset request pulls the
// core back into reset. Lock losses that happen while running are counted,
// saturating, so they can be inspected during debug.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int CNT_WIDTH          = 16,
  parameter int LOSS_WIDTH         = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  pllLocked,
  input  logic                  softReset,
  output logic                  coreReset,
  output logic                  coreResetN,
  output logic                  lockStable,
  output logic [LOSS_WIDTH-1:0] lossCount
);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABLE    = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_sync;
  logic [1:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [LOSS_WIDTH-1:0]  loss_q, loss_d;
  logic                   core_rst_q;

  // pllLocked is asynchronous to clk, so it passes through a plain shift-register synchroniser
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], pllLocked};
  end

  assign lock_sync = sync_q[SYNC_STAGES-1];

  // Next-state logic: in every state a lock loss takes priority over a soft reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_sync) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        if (!lock_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (softReset) begin
          // A held request keeps restarting the hold window
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (!lock_sync) begin
          // Only losses seen while running are counted, not those during qualification
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          if (loss_q != '1) loss_d = loss_q + LOSS_WIDTH'(1);
        end else if (softReset) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and the reset flop. The reset flop is loaded from the next state,
  // so it moves on the same edge as the state register and stays glitch-free.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_WAIT_LOCK;
      cnt_q      <= '0;
      loss_q     <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loss_q     <= loss_d;
      core_rst_q <= (state_d != ST_RUN);
    end
  end

  assign coreReset  = core_rst_q;
  assign coreResetN = ~core_rst_q;
  assign lockStable = lock_sync;
  assign lossCount  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer using small qualification windows:
// 2 sync stages, 8 stable cycles and 4 hold cycles, so release comes 15 edges
// after lock is first sampled. The loss counter is 2 bits wide so that
// saturation can be reached quickly.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       resetN;
  logic       pllLocked;
  logic       softReset;
  logic       coreReset;
  logic       coreResetN;
  logic       lockStable;
  logic [1:0] lossCount;

  int n_checks = 0;
  int n_fails  = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(8), .RESET_HOLD_CYCLES(4),
    .CNT_WIDTH(4), .LOSS_WIDTH(2)
  ) dut (
    .clk(clk), .resetN(resetN), .pllLocked(pllLocked), .softReset(softReset),
    .coreReset(coreReset), .coreResetN(coreResetN), .lockStable(lockStable),
    .lossCount(lossCount)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after each edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetN    = 1'b0;
    pllLocked = 1'b0;
    softReset = 1'b0;
    step(3);
    check("rst_coreReset", 32'(coreReset), 1);
    check("rst_coreResetN", 32'(coreResetN), 0);
    check("rst_lockStable", 32'(lockStable), 0);
    check("rst_lossCount", 32'(lossCount), 0);

    // 1: release reset with lock held, then count the edges until release
    resetN    = 1'b1;
    pllLocked = 1'b1;
    step(1);
    check("t1_sync_e1", 32'(lockStable), 0);
    step(1);
    check("t1_sync_e2", 32'(lockStable), 1);
    step(12);
    check("t1_held_e14", 32'(coreReset), 1);
    step(1);
    check("t1_rel_e15", 32'(coreReset), 0);
    check("t1_relN_e15", 32'(coreResetN), 1);

    // 2: lock loss while running, then re-lock
    pllLocked = 1'b0;
    step(2);
    check("t2_run_e2", 32'(coreReset), 0);
    step(1);
    check("t2_rst_e3", 32'(coreReset), 1);
    check("t2_loss", 32'(lossCount), 1);
    pllLocked = 1'b1;
    step(14);
    check("t2_held_e14", 32'(coreReset), 1);
    step(1);
    check("t2_rel_e15", 32'(coreReset), 0);

    // 4: one-cycle soft reset pulse, then a soft reset held for 10 cycles
    softReset = 1'b1;
    step(1);
    check("t4_pulse_e1", 32'(coreReset), 1);
    softReset = 1'b0;
    step(3);
    check("t4_pulse_e4", 32'(coreReset), 1);
    step(1);
    check("t4_pulse_e5", 32'(coreReset), 0);
    softReset = 1'b1;
    step(10);
    check("t4_held", 32'(coreReset), 1);
    softReset = 1'b0;
    step(3);
    check("t4_drop_e3", 32'(coreReset), 1);
    step(1);
    check("t4_drop_e4", 32'(coreReset), 0);
    check("t4_loss", 32'(lossCount), 1);

    // 6: lock loss and soft reset seen on the same edge; the lock loss must win
    pllLocked = 1'b0;
    step(2);
    softReset = 1'b1;
    step(1);
    check("t6_rst", 32'(coreReset), 1);
    check("t6_loss", 32'(lossCount), 2);
    softReset = 1'b0;
    pllLocked = 1'b1;
    step(14);
    check("t6_held_e14", 32'(coreReset), 1);
    step(1);
    check("t6_rel_e15", 32'(coreReset), 0);

    // Asynchronous reset in the middle of a cycle
    #2;
    resetN = 1'b0;
    #1;
    check("ar_coreReset", 32'(coreReset), 1);
    check("ar_coreResetN", 32'(coreResetN), 0);
    check("ar_lossCount", 32'(lossCount), 0);
    check("ar_lockStable", 32'(lockStable), 0);
    step(2);

    // 3: a one-cycle lock glitch during qualification restarts it
    resetN    = 1'b1;
    pllLocked = 1'b1;
    step(4);
    pllLocked = 1'b0;
    step(1);
    pllLocked = 1'b1;
    step(1);
    check("t3_glitch_sync", 32'(lockStable), 0);
    step(13);
    check("t3_held_relock_e14", 32'(coreReset), 1);
    step(1);
    check("t3_rel_relock_e15", 32'(coreReset), 0);
    check("t3_loss", 32'(lossCount), 0);

    // 5: five loss/re-lock cycles from RUN; the 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      pllLocked = 1'b0;
      step(3);
      check($sformatf("t5_rst_%0d", k), 32'(coreReset), 1);
      check($sformatf("t5_loss_%0d", k), 32'(lossCount), (k < 2) ? k + 1 : 3);
      pllLocked = 1'b1;
      step(15);
      check($sformatf("t5_rel_%0d", k), 32'(coreReset), 0);
    end
    #3;
    resetN = 1'b0;
    #1;
    check("t5_ar_loss", 32'(lossCount), 0);
    check("t5_ar_coreReset", 32'(coreReset), 1);
    check("t5_ar_coreResetN", 32'(coreResetN), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
